// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_arith_pkg
// Description : Shared types and helpers for the bit-serial arithmetic blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width; never below one bit, even for degenerate widths.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/fa_cell.sv
`default_nettype none
// ============================================================================
// Module      : fa_cell
// Description : Combinational one-bit full adder built from XOR/AND/OR.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic w_p;

    assign w_p = a ^ b;
    assign s   = w_p ^ cin;
    assign co  = (a & b) | (cin & w_p);

endmodule : fa_cell
`default_nettype wire

// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_sub
// Description : Bit-serial adder/subtractor, one bit per clock, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_sub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int                 c_cnt_w    = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_res;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic               r_cmsb;
    logic               w_s;
    logic               w_co;
    logic               w_last;

    assign w_last = (r_cnt == c_cnt_last);

    fa_cell u_fa (
        .a   (r_sa[0]),
        .b   (r_sb[0]),
        .cin (r_carry),
        .s   (w_s),
        .co  (w_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = BUSY;
            BUSY:    if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    // Handshake flags decode only the registered state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted at load, carry seeded with sub.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cmsb  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sa    <= a;
                        r_sb    <= sub ? ~b : b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                    end
                end
                BUSY: begin
                    r_res   <= {w_s, r_res[WIDTH-1:1]};
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + c_cnt_one;
                    if (w_last) begin
                        r_cmsb <= r_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_res;
    assign cout = r_carry;
    assign ovf  = r_cmsb ^ r_carry;

endmodule : serial_add_sub
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_sub
// Description : Scoreboard bench for serial_add_sub (WIDTH=8 and WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_sub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  sum;
    logic        cout;
    logic        ovf;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        sub16 = 1'b0;
    logic        out_valid16;
    logic        out_ready16 = 1'b1;
    logic [15:0] sum16;
    logic        cout16;
    logic        ovf16;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [9:0]  q8[$];
    logic [17:0] q16[$];
    logic [9:0]  m_exp8;
    logic [17:0] m_exp16;

    serial_add_sub #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_add_sub #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .sub(sub16), .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitors: pop and compare whenever a result handshake is about to complete.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result8 got sum=%h cout=%0b ovf=%0b required none", sum, cout, ovf);
            end else begin
                m_exp8 = q8.pop_front();
                if ({sum, cout, ovf} !== m_exp8) begin
                    errors++;
                    $display("FAIL result8 got sum=%h cout=%0b ovf=%0b required sum=%h cout=%0b ovf=%0b",
                             sum, cout, ovf, m_exp8[9:2], m_exp8[1], m_exp8[0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid16 && out_ready16) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result16 got sum=%h required none", sum16);
            end else begin
                m_exp16 = q16.pop_front();
                if ({sum16, cout16, ovf16} !== m_exp16) begin
                    errors++;
                    $display("FAIL result16 got sum=%h cout=%0b ovf=%0b required sum=%h cout=%0b ovf=%0b",
                             sum16, cout16, ovf16, m_exp16[17:2], m_exp16[1], m_exp16[0]);
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the acceptance edge.
    task automatic issue8(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                          input logic [9:0] exp, input logic push, output int acc_cyc);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout in_ready=%0b required 1", in_ready);
        end
        a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
        if (push) q8.push_back(exp);
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1; k++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, acc1, acc2, k, n;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum_cout_ovf", 32'({sum, cout, ovf}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Add without carry, with exact latency
        out_ready = 1'b1;
        issue8(8'h3C, 8'h42, 1'b0, {8'h7E, 1'b0, 1'b0}, 1'b1, acc0);
        wait_valid(k);
        check("latency", 32'(k), 32'd8);

        issue8(8'hFF, 8'h01, 1'b0, {8'h00, 1'b1, 1'b0}, 1'b1, acc0);
        issue8(8'h7F, 8'h01, 1'b0, {8'h80, 1'b0, 1'b1}, 1'b1, acc0);
        issue8(8'h05, 8'h07, 1'b1, {8'hFE, 1'b0, 1'b0}, 1'b1, acc0);
        issue8(8'h80, 8'h01, 1'b1, {8'h7F, 1'b1, 1'b1}, 1'b1, acc0);

        // Backpressure with ignored operands during BUSY
        n = 0;
        while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
        out_ready = 1'b0;
        issue8(8'h05, 8'h07, 1'b1, {8'hFE, 1'b0, 1'b0}, 1'b1, acc0);
        a = 8'hAA; b = 8'h55; sub = 1'b0; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(k);
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold", 32'({out_valid, in_ready, sum, cout, ovf}), 32'({1'b1, 1'b0, 8'hFE, 1'b0, 1'b0}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 32'({in_ready, out_valid}), 32'b10);

        // Asynchronous reset in the 4th BUSY cycle
        issue8(8'h11, 8'h22, 1'b0, 10'h0, 1'b0, acc0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_flags", 32'({out_valid, in_ready}), 32'b01);
        check("rst_mid_sum", 32'(sum), 32'h0);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("rst_no_result", 32'(seen), 32'd0);
        issue8(8'h10, 8'h20, 1'b0, {8'h30, 1'b0, 1'b0}, 1'b1, acc0);

        // Back-to-back, out_ready held high
        n = 0;
        while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
        issue8(8'h64, 8'h1E, 1'b0, {8'h82, 1'b0, 1'b1}, 1'b1, acc0);
        issue8(8'hC8, 8'h32, 1'b1, {8'h96, 1'b1, 1'b0}, 1'b1, acc1);
        issue8(8'h0F, 8'hF1, 1'b0, {8'h00, 1'b1, 1'b0}, 1'b1, acc2);
        check("ii_first",  32'(acc1 - acc0), 32'd10);
        check("ii_second", 32'(acc2 - acc1), 32'd10);

        // WIDTH=16 wrap-around
        a16 = 16'hFFFF; b16 = 16'h0001; sub16 = 1'b0; in_valid16 = 1'b1;
        q16.push_back({16'h0000, 1'b1, 1'b0});
        @(posedge clk); #1;
        in_valid16 = 1'b0;

        n = 0;
        while ((q8.size() != 0 || q16.size() != 0) && n < 80) begin
            @(posedge clk); #1; n++;
        end
        check("queues_drained", 32'(q8.size() + q16.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_add_sub
`default_nettype wire
